// File: rtl/seq_checker.sv
// -----------------------------------------------------------------------------
// seq_checker
//
// Watches the count stream of an upstream arbitrary-sequence JK counter and
// checks it against the fixed cyclic reference 4,11,2,0,4,2,10,3,15,1.
//
// The block starts in SEARCH. In SEARCH it waits for a value that occurs only
// once in the reference. That value fixes the position, and the block moves to
// LOCKED. In LOCKED every valid sample must be the next reference value.
//
// A deviation in LOCKED, or an illegal value in SEARCH, is an error event. An
// error event:
//   - pulses ERR for one cycle,
//   - sets the sticky flag ERRS,
//   - bumps the saturating count ERRN.
// A deviation in LOCKED also drops the block back to SEARCH.
//
// Completed laps (index 9 -> 0 while locked) are counted in LAPS, which
// saturates at all-ones.
//
// Every output comes straight from a register, so a sample taken on an edge
// shows its effect on the outputs after that same edge. This is the
// one-cycle latency from a sampled Q to the outputs.
// -----------------------------------------------------------------------------
module seq_checker #(
    parameter int LAP_W = 8,
    parameter int ERR_W = 4
) (
    input  logic             C,
    input  logic             nR,
    input  logic [3:0]       Q,
    input  logic             V,
    input  logic             CLR,
    output logic             LOCK,
    output logic [3:0]       POS,
    output logic             ERR,
    output logic             ERRS,
    output logic [ERR_W-1:0] ERRN,
    output logic [LAP_W-1:0] LAPS
);

    // Highest index of the reference sequence; the index after it is 0.
    localparam logic [3:0] LAST_IDX = 4'd9;

    typedef enum logic {
        SEARCH = 1'b0,
        LOCKED = 1'b1
    } state_e;

    // How a sampled value relates to the reference sequence.
    typedef enum logic [1:0] {
        CLS_UNIQUE  = 2'd0,  // appears at exactly one index
        CLS_AMBIG   = 2'd1,  // appears at more than one index
        CLS_ILLEGAL = 2'd2   // never appears
    } cls_e;

    // -------------------------------------------------------------------------
    // Reference sequence helpers
    // -------------------------------------------------------------------------

    // Reference value at a given index. Indices 10..15 never occur.
    function automatic logic [3:0] seq_at(input logic [3:0] idx);
        logic [3:0] val;
        case (idx)
            4'd0:    val = 4'd4;
            4'd1:    val = 4'd11;
            4'd2:    val = 4'd2;
            4'd3:    val = 4'd0;
            4'd4:    val = 4'd4;
            4'd5:    val = 4'd2;
            4'd6:    val = 4'd10;
            4'd7:    val = 4'd3;
            4'd8:    val = 4'd15;
            4'd9:    val = 4'd1;
            default: val = 4'd0;
        endcase
        return val;
    endfunction

    // Cyclic successor index: 9 wraps back to 0.
    function automatic logic [3:0] next_idx(input logic [3:0] idx);
        return (idx == LAST_IDX) ? 4'd0 : idx + 4'd1;
    endfunction

    // Classify a sampled value against the reference sequence.
    function automatic cls_e classify(input logic [3:0] val);
        cls_e cls;
        case (val)
            4'd11, 4'd0, 4'd10, 4'd3, 4'd15, 4'd1: cls = CLS_UNIQUE;
            4'd4, 4'd2:                            cls = CLS_AMBIG;
            default:                               cls = CLS_ILLEGAL;
        endcase
        return cls;
    endfunction

    // Index of a unique value. Returns 0 for any other value; callers only
    // use it after classify() has reported CLS_UNIQUE.
    function automatic logic [3:0] unique_idx(input logic [3:0] val);
        logic [3:0] idx;
        case (val)
            4'd11:   idx = 4'd1;
            4'd0:    idx = 4'd3;
            4'd10:   idx = 4'd6;
            4'd3:    idx = 4'd7;
            4'd15:   idx = 4'd8;
            4'd1:    idx = 4'd9;
            default: idx = 4'd0;
        endcase
        return idx;
    endfunction

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    state_e           state_q, state_d;
    logic [3:0]       pos_q,   pos_d;
    logic             err_q,   err_d;
    logic             errs_q,  errs_d;
    logic [ERR_W-1:0] errn_q,  errn_d;
    logic [LAP_W-1:0] laps_q,  laps_d;

    // Decoded view of the current sample.
    cls_e       q_cls;
    logic [3:0] q_idx;
    logic [3:0] pos_next;
    logic       err_event;

    // Classify the incoming value and find the index expected after POS.
    always_comb begin
        q_cls    = classify(Q);
        q_idx    = unique_idx(Q);
        pos_next = next_idx(pos_q);
    end

    // Next-state, position, lap and error-event logic for the SEARCH/LOCKED FSM.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can
        // leave one unassigned and infer a latch.
        state_d   = state_q;
        pos_d     = pos_q;
        laps_d    = laps_q;
        err_event = 1'b0;

        if (V) begin
            unique case (state_q)
                SEARCH: begin
                    if (q_cls == CLS_UNIQUE) begin
                        state_d = LOCKED;
                        pos_d   = q_idx;
                    end else if (q_cls == CLS_ILLEGAL) begin
                        err_event = 1'b1;
                    end
                    // An ambiguous value cannot fix the position: keep waiting.
                end

                LOCKED: begin
                    if (Q == seq_at(pos_next)) begin
                        pos_d = pos_next;
                        // Only a 9->0 step made while locked completes a lap.
                        if (pos_q == LAST_IDX && laps_q != {LAP_W{1'b1}}) begin
                            laps_d = laps_q + 1'b1;
                        end
                    end else begin
                        // Drop the lock. Relocking waits for the next sample,
                        // even when this Q is itself unique.
                        err_event = 1'b1;
                        state_d   = SEARCH;
                        pos_d     = 4'd0;
                    end
                end

                default: begin
                    state_d = SEARCH;
                    pos_d   = 4'd0;
                end
            endcase
        end
    end

    // Error reporting: one-cycle pulse, sticky flag and saturating count.
    // An error in the same cycle as CLR wins over the clear.
    always_comb begin
        err_d  = err_event;
        errs_d = errs_q;
        errn_d = errn_q;

        if (err_event) begin
            errs_d = 1'b1;
            if (CLR) begin
                errn_d = {{(ERR_W-1){1'b0}}, 1'b1};
            end else if (errn_q != {ERR_W{1'b1}}) begin
                errn_d = errn_q + 1'b1;
            end
        end else if (CLR) begin
            errs_d = 1'b0;
            errn_d = '0;
        end
    end

    // State register with asynchronous active-low reset.
    always_ff @(posedge C or negedge nR) begin
        // NOTE: the reset is asynchronous, so it sits in the sensitivity list
        // and all outputs clear the moment nR falls, without waiting for C.
        if (!nR) begin
            state_q <= SEARCH;
            pos_q   <= 4'd0;
            err_q   <= 1'b0;
            errs_q  <= 1'b0;
            errn_q  <= '0;
            laps_q  <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments, so every
            // register samples the pre-edge values of the others.
            state_q <= state_d;
            pos_q   <= pos_d;
            err_q   <= err_d;
            errs_q  <= errs_d;
            errn_q  <= errn_d;
            laps_q  <= laps_d;
        end
    end

    // Outputs are taken directly from the registers.
    assign LOCK = (state_q == LOCKED);
    assign POS  = pos_q;
    assign ERR  = err_q;
    assign ERRS = errs_q;
    assign ERRN = errn_q;
    assign LAPS = laps_q;

endmodule

// File: tb/tb_seq_checker.sv
// -----------------------------------------------------------------------------
// tb_seq_checker
//
// Directed-vector bench for seq_checker. Each vector applies one sample and
// lists the hand-computed outputs expected after that sample's edge.
//
// Inputs change on the falling edge. Outputs are sampled 1 ns after the
// rising edge.
// -----------------------------------------------------------------------------
module tb_seq_checker;

    localparam int LAP_W = 8;
    localparam int ERR_W = 4;

    logic             C;
    logic             nR;
    logic [3:0]       Q;
    logic             V;
    logic             CLR;
    logic             LOCK;
    logic [3:0]       POS;
    logic             ERR;
    logic             ERRS;
    logic [ERR_W-1:0] ERRN;
    logic [LAP_W-1:0] LAPS;

    int n_compared   = 0;
    int n_mismatched = 0;

    seq_checker #(
        .LAP_W (LAP_W),
        .ERR_W (ERR_W)
    ) dut (
        .C    (C),
        .nR   (nR),
        .Q    (Q),
        .V    (V),
        .CLR  (CLR),
        .LOCK (LOCK),
        .POS  (POS),
        .ERR  (ERR),
        .ERRS (ERRS),
        .ERRN (ERRN),
        .LAPS (LAPS)
    );

    // 10 ns clock.
    initial C = 1'b0;
    always #5 C = ~C;

    // Safety net so the run always ends.
    initial begin
        #100000;
        $display("FAIL watchdog: run did not finish, got timeout, required completion");
        $fatal(1, "watchdog expired");
    end

    // Count one comparison and report it if it does not match.
    task automatic check(input string tag, input int observed, input int expected);
        n_compared++;
        if (observed != expected) begin
            n_mismatched++;
            $display("FAIL %s: got %0d, required %0d", tag, observed, expected);
        end
    endtask

    // Compare all six outputs against the expected values.
    task automatic expect_all(input string tag, input int lock, input int pos,
                              input int err, input int errs, input int errn,
                              input int laps);
        check({tag, ".LOCK"}, int'(LOCK), lock);
        check({tag, ".POS"},  int'(POS),  pos);
        check({tag, ".ERR"},  int'(ERR),  err);
        check({tag, ".ERRS"}, int'(ERRS), errs);
        check({tag, ".ERRN"}, int'(ERRN), errn);
        check({tag, ".LAPS"}, int'(LAPS), laps);
    endtask

    // Apply one sample, clock it in, then check the outputs that follow.
    task automatic vec(input string tag, input logic v, input int q,
                       input logic clr, input int lock, input int pos,
                       input int err, input int errs, input int errn,
                       input int laps);
        @(negedge C);
        V   = v;
        Q   = 4'(q);
        CLR = clr;
        @(posedge C);
        #1;
        expect_all(tag, lock, pos, err, errs, errn, laps);
    endtask

    initial begin
        nR  = 1'b0;
        V   = 1'b0;
        Q   = 4'd0;
        CLR = 1'b0;

        // Reset state.
        #12;
        expect_all("reset", 0, 0, 0, 0, 0, 0);
        @(negedge C);
        nR = 1'b1;

        // Clean stream: lock on 11, count a lap after the second 4.
        //    tag      V  Q   CLR  LOCK POS ERR ERRS ERRN LAPS
        vec("s1_4a",  1, 4,  0,   0,   0,  0,  0,   0,   0);
        vec("s1_11",  1, 11, 0,   1,   1,  0,  0,   0,   0);
        vec("s1_2",   1, 2,  0,   1,   2,  0,  0,   0,   0);
        vec("s1_0",   1, 0,  0,   1,   3,  0,  0,   0,   0);
        vec("s1_4b",  1, 4,  0,   1,   4,  0,  0,   0,   0);
        vec("s1_2b",  1, 2,  0,   1,   5,  0,  0,   0,   0);
        vec("s1_10",  1, 10, 0,   1,   6,  0,  0,   0,   0);
        vec("s1_3",   1, 3,  0,   1,   7,  0,  0,   0,   0);
        vec("s1_15",  1, 15, 0,   1,   8,  0,  0,   0,   0);
        vec("s1_1",   1, 1,  0,   1,   9,  0,  0,   0,   0);
        vec("s1_lap", 1, 4,  0,   1,   0,  0,  0,   0,   1);
        vec("s1_11b", 1, 11, 0,   1,   1,  0,  0,   0,   1);

        // Deviation at POS=3, then relock on 10.
        vec("s2_2",   1, 2,  0,   1,   2,  0,  0,   0,   1);
        vec("s2_0",   1, 0,  0,   1,   3,  0,  0,   0,   1);
        vec("s2_bad", 1, 5,  0,   0,   0,  1,  1,   1,   1);
        vec("s2_rel", 1, 10, 0,   1,   6,  0,  1,   1,   1);

        // V toggling: POS moves only on V=1; junk on V=0 is ignored.
        vec("v_3",    1, 3,  0,   1,   7,  0,  1,   1,   1);
        vec("v_off1", 0, 5,  0,   1,   7,  0,  1,   1,   1);
        vec("v_15",   1, 15, 0,   1,   8,  0,  1,   1,   1);
        vec("v_off2", 0, 0,  0,   1,   8,  0,  1,   1,   1);
        vec("v_1",    1, 1,  0,   1,   9,  0,  1,   1,   1);
        vec("v_off3", 0, 4,  0,   1,   9,  0,  1,   1,   1);
        vec("v_lap",  1, 4,  0,   1,   0,  0,  1,   1,   2);

        // CLR clears the error state only, not the lock, POS or LAPS.
        vec("clr_lk", 1, 11, 1,   1,   1,  0,  0,   0,   2);

        // SEARCH on ambiguous values, then an illegal value.
        vec("s3_mis", 1, 4,  0,   0,   0,  1,  1,   1,   2);
        vec("s3_4a",  1, 4,  1,   0,   0,  0,  0,   0,   2);
        vec("s3_2a",  1, 2,  0,   0,   0,  0,  0,   0,   2);
        vec("s3_4b",  1, 4,  0,   0,   0,  0,  0,   0,   2);
        vec("s3_2b",  1, 2,  0,   0,   0,  0,  0,   0,   2);
        vec("s3_ill", 1, 12, 0,   0,   0,  1,  1,   1,   2);

        // ERRN saturation, then CLR coincident with an error.
        vec("s4_clr", 1, 4,  1,   0,   0,  0,  0,   0,   2);
        for (int i = 1; i <= 17; i++) begin
            vec($sformatf("s4_e%0d", i), 1, 12, 0, 0, 0, 1, 1,
                (i > 15) ? 15 : i, 2);
        end
        vec("s4_cle", 1, 13, 1,   0,   0,  1,  1,   1,   2);
        vec("s4_cl2", 1, 4,  1,   0,   0,  0,  0,   0,   2);

        // Reach LOCKED at POS=7 with LAPS=3.
        vec("s5_1",   1, 1,  0,   1,   9,  0,  0,   0,   2);
        vec("s5_lap", 1, 4,  0,   1,   0,  0,  0,   0,   3);
        vec("s5_11",  1, 11, 0,   1,   1,  0,  0,   0,   3);
        vec("s5_2",   1, 2,  0,   1,   2,  0,  0,   0,   3);
        vec("s5_0",   1, 0,  0,   1,   3,  0,  0,   0,   3);
        vec("s5_4",   1, 4,  0,   1,   4,  0,  0,   0,   3);
        vec("s5_2b",  1, 2,  0,   1,   5,  0,  0,   0,   3);
        vec("s5_10",  1, 10, 0,   1,   6,  0,  0,   0,   3);
        vec("s5_3",   1, 3,  0,   1,   7,  0,  0,   0,   3);

        // Asynchronous reset pulse between edges: outputs clear before the
        // next edge arrives.
        #1;
        nR = 1'b0;
        #1;
        expect_all("s5_arst", 0, 0, 0, 0, 0, 0);
        nR = 1'b1;

        // Resynchronise after reset.
        vec("s6_amb", 1, 2,  0,   0,   0,  0,  0,   0,   0);
        vec("s6_lk",  1, 15, 0,   1,   8,  0,  0,   0,   0);
        vec("s6_1",   1, 1,  0,   1,   9,  0,  0,   0,   0);
        vec("s6_lap", 1, 4,  0,   1,   0,  0,  0,   0,   1);

        // A unique but wrong value while locked does not relock in the same
        // cycle; the next sample relocks.
        vec("s7_mis", 1, 15, 0,   0,   0,  1,  1,   1,   1);
        vec("s7_rel", 1, 15, 0,   1,   8,  0,  1,   1,   1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
